// File: rtl/escalonador_transmissao.sv
// Round-robin scheduler sharing one serial face transmitter among N_FACES requesters.
// Grant one cycle after an idle request; waits for a tx_fim rising edge or TIMEOUT cycles; requests are level-held, never dropped.
module escalonador_transmissao #(
  parameter int N_FACES = 6,
  parameter int TIMEOUT = 2_000_000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_FACES-1:0] pedido,
  input  logic               tx_fim,
  output logic               tx_iniciar,
  output logic [2:0]         tx_face,
  output logic [N_FACES-1:0] concede,
  output logic [N_FACES-1:0] atendido,
  output logic               erro,
  output logic               ocupado,
  output logic [3:0]         db_estado
);

  localparam int            TW        = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);
  localparam logic [2:0]    ULTIMA    = 3'(N_FACES - 1);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    INICIA  = 3'd1,
    AGUARDA = 3'd2,
    CONCLUI = 3'd3,
    ERRO    = 3'd4
  } estado_t;

  estado_t               estado;
  estado_t               prox_estado;
  logic [2:0]            ponteiro;
  logic [2:0]            face;
  logic [TW-1:0]         timer;
  logic                  fim_ant;
  logic                  borda;
  logic [2:0]            escolha;
  logic [2:0]            face_seguinte;
  logic [N_FACES-1:0]    um_quente;

  // First requester at or after p, scanning circularly.
  function automatic logic [2:0] proxima(input logic [2:0] p, input logic [N_FACES-1:0] req);
    logic [2:0] r;
    logic [2:0] s3;
    logic       achou;
    int         s;
    r     = p;
    achou = 1'b0;
    for (int k = 0; k < N_FACES; k++) begin
      s = int'(p) + k;
      if (s >= N_FACES) s = s - N_FACES;
      s3 = 3'(s);
      if (!achou && req[s3]) begin
        r     = s3;
        achou = 1'b1;
      end
    end
    return r;
  endfunction

  assign escolha       = proxima(ponteiro, pedido);
  assign face_seguinte = (face == ULTIMA) ? 3'd0 : face + 3'd1;
  assign um_quente     = N_FACES'(1) << face;
  // A level already high on entry to AGUARDA is ignored because fim_ant tracks tx_fim in every state.
  assign borda         = tx_fim & ~fim_ant;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= OCIOSO;
    else        estado <= prox_estado;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ponteiro <= 3'd0;
      face     <= 3'd0;
      timer    <= '0;
      fim_ant  <= 1'b1;
    end else begin
      fim_ant <= tx_fim;
      case (estado)
        OCIOSO:  if (|pedido) face <= escolha;
        INICIA:  timer <= '0;
        AGUARDA: if (!borda && timer != TIMER_MAX) timer <= timer + TW'(1);
        CONCLUI: ponteiro <= face_seguinte;
        ERRO:    ponteiro <= face_seguinte;
        default: ;
      endcase
    end
  end

  always_comb begin
    prox_estado = estado;
    case (estado)
      OCIOSO:  if (|pedido) prox_estado = INICIA;
      INICIA:  prox_estado = AGUARDA;
      AGUARDA: begin
        if (borda)                   prox_estado = CONCLUI;
        else if (timer == TIMER_MAX) prox_estado = ERRO;
      end
      CONCLUI: prox_estado = OCIOSO;
      ERRO:    prox_estado = OCIOSO;
      default: prox_estado = OCIOSO;
    endcase
  end

  always_comb begin
    tx_iniciar = 1'b0;
    concede    = '0;
    atendido   = '0;
    erro       = 1'b0;
    ocupado    = 1'b1;
    case (estado)
      OCIOSO:  ocupado = 1'b0;
      INICIA: begin
        tx_iniciar = 1'b1;
        concede    = um_quente;
      end
      AGUARDA: concede = um_quente;
      CONCLUI: begin
        concede  = um_quente;
        atendido = um_quente;
      end
      ERRO: begin
        concede = um_quente;
        erro    = 1'b1;
      end
      default: ;
    endcase
  end

  assign tx_face   = face;
  assign db_estado = {1'b0, estado};

endmodule

// File: tb/tb_escalonador_transmissao.sv
// Scoreboarded random bench: a round-robin model predicts grant order and each transfer's outcome.
module tb_escalonador_transmissao;
  localparam int TMO = 20;

  logic       clock  = 1'b0;
  logic       reset  = 1'b0;
  logic [5:0] pedido = 6'd0;
  logic       tx_fim = 1'b0;
  logic       tx_iniciar;
  logic [2:0] tx_face;
  logic [5:0] concede;
  logic [5:0] atendido;
  logic       erro;
  logic       ocupado;
  logic [3:0] db_estado;

  escalonador_transmissao #(.N_FACES(6), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .pedido(pedido), .tx_fim(tx_fim),
    .tx_iniciar(tx_iniciar), .tx_face(tx_face), .concede(concede),
    .atendido(atendido), .erro(erro), .ocupado(ocupado), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    int face;
    bit ok;
    int dt;
  } exp_t;

  exp_t      exp_q[$];
  bit [31:0] plan_q[$];
  int        total = 0;
  int        bad   = 0;
  int        cyc   = 0;
  int        ptr_m = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int rr(input int p, input logic [5:0] req);
    for (int k = 0; k < 6; k++)
      if (req[(p + k) % 6]) return (p + k) % 6;
    return -1;
  endfunction

  // Bit j is the tx_fim level driven j cycles after the start pulse is seen.
  function automatic bit [31:0] make_plan(input int kind, input int d);
    bit [31:0] p;
    p = 32'd0;
    case (kind)
      0: for (int j = 0; j < 32; j++) p[j] = (j >= d);
      1: p = 32'd0;
      2: for (int j = 0; j < 32; j++) p[j] = (j < d) || (j >= d + 3);
      default: p = $urandom;
    endcase
    return p;
  endfunction

  // Success iff a rising edge lands inside the AGUARDA window.
  task automatic outcome(input bit [31:0] p, output bit ok, output int dt);
    ok = 1'b0;
    dt = TMO + 1;
    for (int j = 1; j <= TMO; j++)
      if (!ok && p[j] && !p[j-1]) begin
        ok = 1'b1;
        dt = j + 1;
      end
  endtask

  // Transmitter model
  initial begin
    bit [31:0] p;
    forever begin
      @(negedge clock);
      if (reset && tx_iniciar && plan_q.size() != 0) begin
        p = plan_q.pop_front();
        for (int j = 0; j <= TMO + 1; j++) begin
          tx_fim = p[j];
          @(negedge clock);
          if (!reset || atendido != 6'd0 || erro) break;
        end
      end
    end
  end

  // Monitor
  initial begin
    exp_t       cur;
    bit         in_flight;
    int         t0;
    logic [5:0] oh;
    in_flight = 1'b0;
    t0 = 0;
    cur = '{0, 1'b0, 0};
    forever begin
      @(negedge clock);
      if (!reset) in_flight = 1'b0;
      else begin
        oh = 6'(1 << cur.face);
        if (in_flight && cyc == t0 + 1) begin
          total++;
          if (tx_iniciar !== 1'b0 || db_estado !== 4'd2) begin
            bad++;
            $display("FAIL pulse_len tx_iniciar=%b db_estado=%0d want 0/2", tx_iniciar, db_estado);
          end
        end
        if (tx_iniciar) begin
          total++;
          if (in_flight || exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_start face=%0d at cyc=%0d", tx_face, cyc);
          end else begin
            cur = exp_q.pop_front();
            oh = 6'(1 << cur.face);
            t0 = cyc;
            in_flight = 1'b1;
            if (tx_face !== 3'(cur.face) || concede !== oh || db_estado !== 4'd1 || ocupado !== 1'b1) begin
              bad++;
              $display("FAIL grant face=%0d concede=%b db=%0d ocupado=%b want face=%0d concede=%b db=1 ocupado=1",
                       tx_face, concede, db_estado, ocupado, cur.face, oh);
            end
          end
        end
        if (atendido !== 6'd0 || erro !== 1'b0) begin
          total++;
          if (!in_flight) begin
            bad++;
            $display("FAIL unexpected_done atendido=%b erro=%b at cyc=%0d", atendido, erro, cyc);
          end else begin
            if (atendido !== (cur.ok ? oh : 6'd0) || erro !== (cur.ok ? 1'b0 : 1'b1) ||
                cyc - t0 != cur.dt || concede !== oh ||
                db_estado !== (cur.ok ? 4'd3 : 4'd4)) begin
              bad++;
              $display("FAIL done face=%0d atendido=%b erro=%b dt=%0d db=%0d want ok=%b dt=%0d",
                       cur.face, atendido, erro, cyc - t0, db_estado, cur.ok, cur.dt);
            end
            in_flight = 1'b0;
          end
        end
      end
    end
  end

  task automatic run_test(input logic [5:0] req, input int kind, input int d, input bit drop_err);
    logic [5:0] pm;
    int         f;
    bit         ok;
    int         dt;
    bit [31:0]  p;
    int         guard;
    bit         done;
    pm = req;
    guard = 0;
    done = 1'b0;
    while (pm != 6'd0 && guard < 40) begin
      f = rr(ptr_m, pm);
      p = make_plan(kind, d);
      outcome(p, ok, dt);
      exp_q.push_back('{f, ok, dt});
      plan_q.push_back(p);
      if (ok || drop_err) pm[f] = 1'b0;
      ptr_m = (f + 1) % 6;
      guard++;
    end
    @(negedge clock);
    pedido = req;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(negedge clock);
      if (atendido != 6'd0)      pedido = pedido & ~atendido;
      else if (erro && drop_err) pedido = pedido & ~concede;
      if (pedido == 6'd0 && !ocupado && exp_q.size() == 0) done = 1'b1;
    end
    total++;
    if (!done || plan_q.size() != 0) begin
      bad++;
      $display("FAIL drain req=%b pending_exp=%0d pending_plan=%0d pedido=%b",
               req, exp_q.size(), plan_q.size(), pedido);
      exp_q.delete();
      plan_q.delete();
      pedido = 6'd0;
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    #1;
    total++;
    if (tx_iniciar !== 1'b0 || tx_face !== 3'd0 || concede !== 6'd0 || atendido !== 6'd0 ||
        erro !== 1'b0 || ocupado !== 1'b0 || db_estado !== 4'd0) begin
      bad++;
      $display("FAIL reset_state ini=%b face=%0d concede=%b atendido=%b erro=%b ocupado=%b db=%0d want all 0",
               tx_iniciar, tx_face, concede, atendido, erro, ocupado, db_estado);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    run_test(6'b111111, 0, 3, 1'b0);   // round-robin 0..5
    run_test(6'b000100, 0, 10, 1'b0);  // single request, face 2
    run_test(6'b000010, 1, 0, 1'b1);   // timeout on face 1
    run_test(6'b000101, 0, 5, 1'b0);   // pointer now 2: face 2 then 0
    run_test(6'b010000, 0, 2, 1'b0);   // leaves pointer at 5
    run_test(6'b100001, 0, 4, 1'b0);   // wrap: 5 then 0
    run_test(6'b001001, 2, 6, 1'b0);   // tx_fim level already high
    run_test(6'b000001, 0, TMO, 1'b0); // edge on last timer cycle wins
    run_test(6'b000010, 0, TMO + 1, 1'b1);
    run_test(6'b110000, 0, 1, 1'b0);   // shortest transmitter time

    for (int t = 0; t < 25; t++)
      run_test(6'($urandom_range(1, 63)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, TMO + 3)), 1'b1);

    // Reset in the middle of a transfer
    exp_q.push_back('{rr(ptr_m, 6'b000001), 1'b0, 0});
    plan_q.push_back(32'd0);
    @(negedge clock);
    pedido = 6'b000001;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clock);
      if (tx_iniciar) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL reset_setup no start seen tx_iniciar=%b want 1", tx_iniciar);
    end
    repeat (5) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    total++;
    if (concede !== 6'd0 || ocupado !== 1'b0 || db_estado !== 4'd0) begin
      bad++;
      $display("FAIL async_reset concede=%b ocupado=%b db=%0d want 0/0/0", concede, ocupado, db_estado);
    end
    total++;
    if (tx_iniciar !== 1'b0 || atendido !== 6'd0 || erro !== 1'b0 || tx_face !== 3'd0) begin
      bad++;
      $display("FAIL async_reset_out ini=%b atendido=%b erro=%b face=%0d want 0", tx_iniciar, atendido, erro, tx_face);
    end
    exp_q.delete();
    plan_q.delete();
    pedido = 6'd0;
    ptr_m = 0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    run_test(6'b001000, 0, 4, 1'b0);   // face 3 from pointer 0
    run_test(6'b001001, 0, 7, 1'b0);   // pointer now 4: 0 then 3

    repeat (5) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
